debug_frame_serializer: RTL

//  Consumes the three 32-bit debug words produced by the GAT debug stage
//  (handshake sticky flags, config constants, signature).
//  On a snapshot request it captures all words atomically and emits them as a

---
 rtl/gat_debug_pkg.sv | 18 +
 rtl/debug_frame_serializer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/gat_debug_pkg.sv
// Shared types and constants for the GAT debug frame serializer.
package gat_debug_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY,
    CSUM
  } dbg_ser_state_e;

  localparam logic [7:0] DBG_HEADER = 8'hA5;

  // Total frame length in bytes: header + payload + checksum.
  function automatic int frame_bytes(input int num_words, input int word_w);
    return 2 + num_words * word_w / 8;
  endfunction

endpackage

// File: rtl/debug_frame_serializer.sv
// Captures NUM_WORDS debug words atomically on a request and streams them as
// a byte frame (header, payload MSB-first per word, XOR checksum) over a
// valid/ready interface. Counts completed frames and rejected requests.
module debug_frame_serializer
  import gat_debug_pkg::*;
#(
  parameter int         NUM_WORDS   = 3,
  parameter int         WORD_W      = 32,
  parameter logic [7:0] HEADER      = DBG_HEADER,
  parameter int         AUTO_PERIOD = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_WORDS*WORD_W-1:0] debug_i,
  input  logic                        snap_req_i,
  output logic [7:0]                  tx_data_o,
  output logic                        tx_vld_o,
  input  logic                        tx_rdy_i,
  output logic                        busy_o,
  output logic [15:0]                 frame_cnt_o,
  output logic [15:0]                 drop_cnt_o
);

  localparam int BPW       = WORD_W / 8;
  localparam int PAY_BYTES = frame_bytes(NUM_WORDS, WORD_W) - 2;
  localparam int SNAP_W    = NUM_WORDS * WORD_W;
  localparam int IDX_W     = (PAY_BYTES > 1) ? $clog2(PAY_BYTES) : 1;
  localparam int OFF_W     = $clog2(SNAP_W);

  dbg_ser_state_e    state_q, state_d;
  logic [SNAP_W-1:0] snap_q, snap_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        csum_q, csum_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  logic              auto_tick;
  logic              req;
  logic              hs;
  logic              drop;
  int                word_sel;
  int                byte_sel;
  logic [OFF_W-1:0]  bit_off;
  logic [7:0]        pay_byte;

  // Optional free-running request generator.
  if (AUTO_PERIOD > 0) begin : g_auto
    localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    logic [AW-1:0] auto_cnt_q;

    assign auto_tick = (auto_cnt_q == AW'(AUTO_PERIOD - 1));

    // Count 0..AUTO_PERIOD-1, wrapping on the tick.
    always_ff @(posedge clk) begin
      if (rst || auto_tick) auto_cnt_q <= '0;
      else                  auto_cnt_q <= auto_cnt_q + 1'b1;
    end
  end else begin : g_no_auto
    assign auto_tick = 1'b0;
  end

  // Simultaneous manual and automatic requests merge into one.
  assign req      = snap_req_i | auto_tick;
  assign tx_vld_o = (state_q != IDLE);
  assign busy_o   = (state_q != IDLE);
  assign hs       = tx_vld_o & tx_rdy_i;

  assign frame_cnt_o = frame_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;

  // Select payload byte idx_q: word idx/BPW, most significant byte first.
  always_comb begin
    word_sel = int'(idx_q) / BPW;
    byte_sel = int'(idx_q) % BPW;
    bit_off  = OFF_W'(word_sel * WORD_W + (BPW - 1 - byte_sel) * 8);
    pay_byte = snap_q[bit_off +: 8];
  end

  // Output byte is a pure function of registered state; tx_rdy_i never feeds it.
  always_comb begin
    unique case (state_q)
      HDR:     tx_data_o = HEADER;
      PAY:     tx_data_o = pay_byte;
      CSUM:    tx_data_o = csum_q;
      default: tx_data_o = 8'h00;
    endcase
  end

  // Next-state logic for the frame FSM, counters and snapshot.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    snap_d      = snap_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    drop        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          snap_d  = debug_i;
          state_d = HDR;
        end
      end
      HDR: begin
        drop = req;
        if (hs) begin
          state_d = PAY;
          idx_d   = '0;
          csum_d  = '0;
        end
      end
      PAY: begin
        drop = req;
        if (hs) begin
          csum_d = csum_q ^ pay_byte;
          if (idx_q == IDX_W'(PAY_BYTES - 1)) state_d = CSUM;
          else                                idx_d   = idx_q + 1'b1;
        end
      end
      CSUM: begin
        if (hs) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (req) begin
            snap_d  = debug_i;
            state_d = HDR;
          end else begin
            state_d = IDLE;
          end
        end else begin
          drop = req;
        end
      end
      default: state_d = IDLE;
    endcase

    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // State register with synchronous reset; a reset mid-frame simply aborts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the snapshot is cleared on reset too, so no stale debug data
      // from an aborted frame survives into the next one.
      state_q     <= IDLE;
      snap_q      <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the same
      // pre-edge values regardless of statement order.
      state_q     <= state_d;
      snap_q      <= snap_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule
